// File: rtl/vram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Package     : vram_arb_pkg
// Description : Shared constants for the VRAM bus arbiter: arbiter state
//               encoding and default address width / DMA timeout length.
// Revision    : 1.0 - initial release
// ============================================================================
package vram_arb_pkg;

    // Default memory address width
    localparam int ARB_AW      = 16;
    // Default maximum DMA grant length in clocks (timeout build only)
    localparam int ARB_TIMEOUT = 1024;

    // Arbiter state encoding
    localparam logic [2:0] ARB_CPU     = 3'd0;
    localparam logic [2:0] ARB_DRAIN   = 3'd1;
    localparam logic [2:0] ARB_SETTLE  = 3'd2;
    localparam logic [2:0] ARB_DMA     = 3'd3;
    localparam logic [2:0] ARB_RELEASE = 3'd4;

endpackage
`default_nettype wire

// File: rtl/vram_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : vram_bus_arbiter
// Description : Owns the shared external video/CPU RAM. The CPU holds the bus
//               by default; a VPU hold request halts the CPU at a cycle
//               boundary, drains its pending access, waits SETTLE idle clocks
//               and then hands the address bus to the VPU DMA engine. Read
//               data is returned to the VPU with a fixed 1-clock latency.
//               CPU accesses are registered onto the RAM bus (one clock after
//               the CPU presents them); the DMA address path is combinational.
//               Optional feature: define ARB_TIMEOUT_EN to bound a DMA grant
//               to TIMEOUT clocks and raise a sticky arb_err on expiry.
// Revision    : 1.0 - initial release
// ============================================================================
module vram_bus_arbiter
    import vram_arb_pkg::*;
#(
    parameter int AW      = ARB_AW,
    parameter int SETTLE  = 1,
    parameter int TIMEOUT = ARB_TIMEOUT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] cpu_addr,
    input  logic [7:0]    cpu_do,
    input  logic          cpu_rw,
    input  logic          cpu_vma,
    output logic [7:0]    cpu_di,
    output logic          cpu_halt,
    input  logic          vpu_hold,
    input  logic          vpu_vramcs,
    input  logic [AW-1:0] vpu_addr,
    output logic [7:0]    vpu_data,
    output logic [AW-1:0] mem_addr,
    input  logic [7:0]    mem_din,
    output logic [7:0]    mem_dout,
    output logic          mem_we,
    output logic          mem_oe,
    output logic          arb_err
);

    // Value loaded into the settle counter; counts down to zero
    localparam logic [1:0] c_settle_last = 2'(SETTLE - 1);

    logic [2:0]    r_state;
    logic [1:0]    r_settle_cnt;
    logic          r_cpu_halt;
    logic [AW-1:0] r_mem_addr;
    logic [7:0]    r_mem_dout;
    logic          r_mem_oe;
    logic          r_mem_we;
    logic [7:0]    r_cpu_di;
    logic [7:0]    r_vpu_data;

    logic          w_dma;
    logic          w_req;
    logic          w_tmo_fire;

    assign w_dma = (r_state == ARB_DMA);

`ifdef ARB_TIMEOUT_EN
    localparam logic [15:0] c_tmo_last = 16'(TIMEOUT - 1);

    logic [15:0] r_tmo_cnt;
    logic        r_hold_blk;
    logic        r_arb_err;

    // Last permitted DMA clock reached: the grant is withdrawn this edge
    assign w_tmo_fire = w_dma && (r_tmo_cnt == c_tmo_last);
    // After a forced release, a still-high hold is not a new request
    assign w_req      = vpu_hold & ~r_hold_blk;
    assign arb_err    = r_arb_err;

    // DMA grant length counter, sticky error and re-request blocking
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_tmo_cnt  <= '0;
            r_hold_blk <= 1'b0;
            r_arb_err  <= 1'b0;
        end else begin
            if (w_dma) begin
                r_tmo_cnt <= r_tmo_cnt + 16'd1;
            end else begin
                r_tmo_cnt <= '0;
            end
            if (w_tmo_fire) begin
                r_arb_err <= 1'b1;
            end
            if (!vpu_hold) begin
                r_hold_blk <= 1'b0;
            end else if (w_tmo_fire) begin
                r_hold_blk <= 1'b1;
            end
        end
    end
`else
    assign w_tmo_fire = 1'b0;
    assign w_req      = vpu_hold;
    assign arb_err    = 1'b0;
`endif

    // Bus ownership FSM and registered CPU-side bus signals
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= ARB_CPU;
            r_settle_cnt <= '0;
            r_cpu_halt   <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_dout   <= '0;
            r_mem_oe     <= 1'b0;
            r_mem_we     <= 1'b0;
        end else begin
            case (r_state)
                ARB_CPU: begin
                    // The access presented now is issued next clock, which
                    // is the DRAIN clock if a request arrives this clock.
                    r_mem_addr <= cpu_addr;
                    r_mem_dout <= cpu_do;
                    r_mem_oe   <= cpu_vma & cpu_rw;
                    r_mem_we   <= cpu_vma & ~cpu_rw;
                    if (w_req) begin
                        r_cpu_halt <= 1'b1;
                        r_state    <= ARB_DRAIN;
                    end
                end
                ARB_DRAIN: begin
                    r_mem_oe <= 1'b0;
                    r_mem_we <= 1'b0;
                    if (!vpu_hold) begin
                        r_state <= ARB_RELEASE;
                    end else if (SETTLE == 0) begin
                        r_state <= ARB_DMA;
                    end else begin
                        r_settle_cnt <= c_settle_last;
                        r_state      <= ARB_SETTLE;
                    end
                end
                ARB_SETTLE: begin
                    r_mem_oe <= 1'b0;
                    r_mem_we <= 1'b0;
                    if (!vpu_hold) begin
                        r_state <= ARB_RELEASE;
                    end else if (r_settle_cnt == 2'd0) begin
                        r_state <= ARB_DMA;
                    end else begin
                        r_settle_cnt <= r_settle_cnt - 2'd1;
                    end
                end
                ARB_DMA: begin
                    r_mem_oe <= 1'b0;
                    r_mem_we <= 1'b0;
                    if (w_tmo_fire || !vpu_hold) begin
                        r_state <= ARB_RELEASE;
                    end
                end
                ARB_RELEASE: begin
                    // Hold seen here is ignored; re-arbitration starts in CPU
                    r_mem_oe   <= 1'b0;
                    r_mem_we   <= 1'b0;
                    r_cpu_halt <= 1'b0;
                    r_state    <= ARB_CPU;
                end
                default: begin
                    r_mem_oe   <= 1'b0;
                    r_mem_we   <= 1'b0;
                    r_cpu_halt <= 1'b0;
                    r_state    <= ARB_CPU;
                end
            endcase
        end
    end

    // Read data capture: CPU side while the bus carries CPU cycles, VPU side in DMA
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cpu_di   <= '0;
            r_vpu_data <= '0;
        end else begin
            if ((r_state == ARB_CPU) || (r_state == ARB_DRAIN)) begin
                r_cpu_di <= mem_din;
            end
            if (w_dma) begin
                r_vpu_data <= mem_din;
            end
        end
    end

    assign cpu_di   = r_cpu_di;
    assign cpu_halt = r_cpu_halt;
    assign vpu_data = r_vpu_data;
    assign mem_addr = w_dma ? vpu_addr   : r_mem_addr;
    assign mem_oe   = w_dma ? vpu_vramcs : r_mem_oe;
    assign mem_we   = w_dma ? 1'b0       : r_mem_we;
    assign mem_dout = r_mem_dout;

endmodule
`default_nettype wire
